// File: rtl/alu_operand_fetch_if.sv
// Instruction, operand-bundle and write-back signals of the ALU operand-fetch stage.
interface alu_operand_fetch_if #(
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs;
  logic [AW-1:0] in_rt;
  logic [AW-1:0] in_rd;
  logic [15:0]   in_imm;
  logic          in_use_imm;
  logic [2:0]    in_aluctl;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_a;
  logic [31:0]   out_b;
  logic [2:0]    out_aluctl;
  logic [AW-1:0] out_rd;

  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_data;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_aluctl,
    input  in_ready,
    input  out_valid, out_a, out_b, out_aluctl, out_rd,
    output out_ready,
    output wb_en, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_aluctl,
    output in_ready,
    output out_valid, out_a, out_b, out_aluctl, out_rd,
    input  out_ready,
    input  wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand fetch for the 32-bit ALU: register file with write-back bypass and a
// one-entry registered output buffer toward the ALU.
//   state | meaning
//   EMPTY | no bundle held, out_valid=0
//   FULL  | bundle held for the ALU, out_valid=1
module alu_operand_fetch #(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input logic                clk,
  input logic                rst_n,
  alu_operand_fetch_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [AW-1:0] ZERO_ADDR = '0;

  state_t      state, state_nxt;
  logic        in_ready_c;
  logic        accept;
  logic [31:0] regs [NREGS];
  logic [31:0] rd_a, rd_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    in_ready_c = (state == EMPTY) || bus.out_ready;
    accept     = bus.in_valid && in_ready_c;
    state_nxt  = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL: begin
        if (accept)             state_nxt = FULL;
        else if (bus.out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == FULL);

  // Same-cycle write-back wins over the stored value; address 0 always reads zero.
  always_comb begin
    rd_a = regs[bus.in_rs];
    if (bus.wb_en && (bus.wb_addr == bus.in_rs)) rd_a = bus.wb_data;
    if (bus.in_rs == ZERO_ADDR) rd_a = '0;

    rd_b = regs[bus.in_rt];
    if (bus.wb_en && (bus.wb_addr == bus.in_rt)) rd_b = bus.wb_data;
    if (bus.in_rt == ZERO_ADDR) rd_b = '0;
    if (bus.in_use_imm) rd_b = {16'h0000, bus.in_imm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb_en && (bus.wb_addr != ZERO_ADDR)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_a      <= '0;
      bus.out_b      <= '0;
      bus.out_aluctl <= '0;
      bus.out_rd     <= '0;
    end else if (accept) begin
      bus.out_a      <= rd_a;
      bus.out_b      <= rd_b;
      bus.out_aluctl <= bus.in_aluctl;
      bus.out_rd     <= bus.in_rd;
    end
  end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Scoreboard bench for alu_operand_fetch: directed vectors, mid-stream reset and
// a randomized phase against a small register-file model.
module tb_alu_operand_fetch;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;
    logic [2:0]  rd;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  bundle_t     exp_q[$];
  bundle_t     mon_exp, mon_act;
  logic [31:0] mdl [8];
  logic        mdl_valid;

  alu_operand_fetch_if #(.AW(3)) bus ();

  alu_operand_fetch #(.NREGS(8), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      mon_act = {bus.out_a, bus.out_b, bus.out_aluctl, bus.out_rd};
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_bundle: got %0h with no bundle expected", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("bundle", 128'(mon_act), 128'(mon_exp));
      end
    end
  end

  // Reference register file for the randomized phase
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mdl[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != 3'd0) begin
      mdl[bus.wb_addr] <= bus.wb_data;
    end
  end

  function automatic logic [31:0] mdl_read(input logic [2:0] addr);
    if (addr == 3'd0) return 32'h0;
    if (bus.wb_en && bus.wb_addr == addr) return bus.wb_data;
    return mdl[addr];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [2:0] addr, input logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic [15:0] imm, input logic use_imm, input logic [2:0] ctl,
                       input logic [31:0] ea, input logic [31:0] eb, output int waited);
    bundle_t e;
    bit done = 0;
    bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_imm = imm; bus.in_use_imm = use_imm; bus.in_aluctl = ctl;
    bus.in_valid = 1'b1;
    waited = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e = {ea, eb, ctl, rd};
        exp_q.push_back(e);
        done = 1;
      end else begin
        waited++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL issue_timeout: got no in_ready in 50 cycles, required accept");
    end
  endtask

  initial begin
    int w;
    bus.in_valid = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_rd = 0;
    bus.in_imm = 0; bus.in_use_imm = 0; bus.in_aluctl = 0;
    bus.out_ready = 1;
    set_wb(0, 0, 0);

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_a", 128'(bus.out_a), 128'(0));
    check("rst_out_b", 128'(bus.out_b), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));

    // Write then read
    set_wb(1, 3'd3, 32'hDEADBEEF);
    tick();
    set_wb(0, 0, 0);
    issue(3'd3, 3'd0, 3'd1, 16'h0, 1'b0, 3'b010, 32'hDEADBEEF, 32'h0, w);

    // Same-cycle bypass, and r0 write dropped
    set_wb(1, 3'd5, 32'h12345678);
    issue(3'd5, 3'd5, 3'd2, 16'h0, 1'b0, 3'b001, 32'h12345678, 32'h12345678, w);
    set_wb(1, 3'd0, 32'hFFFFFFFF);
    issue(3'd0, 3'd5, 3'd3, 16'h0, 1'b0, 3'b011, 32'h0, 32'h12345678, w);
    set_wb(0, 0, 0);

    // Immediate is zero-extended and rt is not read
    issue(3'd3, 3'd5, 3'd4, 16'h8001, 1'b1, 3'b100, 32'hDEADBEEF, 32'h00008001, w);
    repeat (2) tick();

    // Backpressure: bundle A held while stalled, write-back does not touch it
    bus.out_ready = 0;
    issue(3'd5, 3'd0, 3'd3, 16'h0001, 1'b1, 3'b100, 32'h12345678, 32'h1, w);
    bus.in_rs = 3'd5; bus.in_rt = 3'd3; bus.in_rd = 3'd4;
    bus.in_use_imm = 0; bus.in_aluctl = 3'b101; bus.in_valid = 1;
    set_wb(1, 3'd5, 32'hCAFEF00D);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", 128'(bus.in_ready), 128'(0));
      check("stall_out_valid", 128'(bus.out_valid), 128'(1));
      check("stall_hold", 128'({bus.out_a, bus.out_b, bus.out_aluctl, bus.out_rd}),
            128'({32'h12345678, 32'h1, 3'b100, 3'd3}));
      tick();
    end
    set_wb(0, 0, 0);
    bus.out_ready = 1;
    issue(3'd5, 3'd3, 3'd4, 16'h0, 1'b0, 3'b101, 32'hCAFEF00D, 32'hDEADBEEF, w);
    check("b2b_first", 128'(w), 128'(0));
    issue(3'd3, 3'd5, 3'd5, 16'h0, 1'b0, 3'b110, 32'hDEADBEEF, 32'hCAFEF00D, w);
    check("b2b_second", 128'(w), 128'(0));
    issue(3'd0, 3'd0, 3'd6, 16'hFFFF, 1'b1, 3'b111, 32'h0, 32'h0000FFFF, w);
    check("b2b_third", 128'(w), 128'(0));
    repeat (2) tick();
    check("drain_valid", 128'(bus.out_valid), 128'(0));

    // Reset while a bundle is pending
    bus.out_ready = 0;
    issue(3'd3, 3'd5, 3'd1, 16'h0, 1'b0, 3'b010, 32'hDEADBEEF, 32'hCAFEF00D, w);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_out_a", 128'(bus.out_a), 128'(0));
    check("midrst_out_b", 128'(bus.out_b), 128'(0));
    exp_q.delete();
    bus.out_ready = 1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int r = 1; r < 8; r++) begin
      issue(3'(r), 3'(r), 3'(r), 16'h0, 1'b0, 3'b000, 32'h0, 32'h0, w);
    end
    repeat (2) tick();

    // Randomized traffic against the model
    mdl_valid = 0;
    for (int c = 0; c < 2000; c++) begin
      logic    exp_ready, acc, nxt;
      bundle_t e;
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.in_rs      = 3'($urandom_range(0, 7));
      bus.in_rt      = 3'($urandom_range(0, 7));
      bus.in_rd      = 3'($urandom_range(0, 7));
      bus.in_imm     = 16'($urandom);
      bus.in_use_imm = 1'($urandom_range(0, 1));
      bus.in_aluctl  = 3'($urandom_range(0, 7));
      set_wb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0) bus.wb_addr = bus.in_rs;
      @(negedge clk);
      exp_ready = !mdl_valid || bus.out_ready;
      check("rnd_in_ready", 128'(bus.in_ready), 128'(exp_ready));
      check("rnd_out_valid", 128'(bus.out_valid), 128'(mdl_valid));
      acc = bus.in_valid && exp_ready;
      if (acc) begin
        e.a   = mdl_read(bus.in_rs);
        e.b   = bus.in_use_imm ? {16'h0, bus.in_imm} : mdl_read(bus.in_rt);
        e.ctl = bus.in_aluctl;
        e.rd  = bus.in_rd;
        exp_q.push_back(e);
      end
      nxt = acc ? 1'b1 : (bus.out_ready ? 1'b0 : mdl_valid);
      @(posedge clk);
      mdl_valid = nxt;
      #1;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    set_wb(0, 0, 0);
    repeat (3) tick();
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
